freq_meter: RTL and testbench

- Measures the frequency of an asynchronous input signal against the system clock. It counts rising edges of `sig_in` during a fixed gate window of GATE_CYCLES system clocks.
- Inverse companion of the team's clock divider: the divider synthesises a known frequency, this block measures an unknown one. Typical uses are checking divider outputs on-board and feeding the display/UART reporting path.
- With the default 100 MHz clock and a 1 ms gate, the result reads directly in kHz.

---
 rtl/freq_meter_pkg.sv | 23 ++
 rtl/freq_meter_sync_edge_detect.sv | 23 ++
 rtl/freq_meter.sv | 125 ++++++++++++
 tb/tb_freq_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
// Imported by the top level and by its testbench.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } fm_state_e;

    localparam int FREC_BASE_MHZ_DEF = 100;

    // A 1 ms gate at the given clock makes the result read in kHz.
    function automatic int gate_cycles_default(input int mhz);
        return mhz * 1000;
    endfunction

    // Saturation value of a width-bit counter (width up to 63).
    function automatic logic [63:0] count_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchroniser plus a rising-edge pulse.
// Reusable for buttons and other asynchronous inputs.
module sync_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    // Shift the raw input through sync1, sync2 and the edge-detect flop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an async signal over a fixed gate window.
// One result per window; optional back-to-back continuous mode.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int FREC_BASE_MHZ = FREC_BASE_MHZ_DEF,
    parameter int GATE_CYCLES   = gate_cycles_default(FREC_BASE_MHZ),
    parameter int COUNT_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sig_in,
    input  logic                   start,
    input  logic                   continuous,
    output logic                   busy,
    output logic                   valid,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   overflow
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX =
        COUNT_WIDTH'(count_max(COUNT_WIDTH));

    fm_state_e              state_q, state_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] freq_q, freq_d;
    logic                   res_ovf_q, res_ovf_d;

    logic                   edge_pulse;
    logic                   at_max;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic                   ovf_inc;

    sync_edge_detect u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .async_i (sig_in),
        .edge_o  (edge_pulse)
    );

    // Saturating count including this cycle's edge, if any.
    always_comb begin
        at_max  = (cnt_q == COUNT_MAX);
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (edge_pulse) begin
            if (at_max) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + 1'b1;
            end
        end
    end

    // Next-state and datapath updates for the measurement FSM.
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        freq_d    = freq_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (gate_q == GATE_LAST) begin
                    freq_d    = cnt_inc;
                    res_ovf_d = ovf_inc;
                    state_d   = DONE;
                end else begin
                    gate_d = gate_q + 1'b1;
                    cnt_d  = cnt_inc;
                    ovf_d  = ovf_inc;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset also clears the last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            freq_q    <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            freq_q    <= freq_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign busy       = (state_q == MEASURE);
    assign valid      = (state_q == DONE);
    assign freq_count = freq_q;
    assign overflow   = res_ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 24-bit and a 3-bit instance
// share one stimulus; both use a 100-cycle gate.
module tb_freq_meter;

    logic        clk;
    logic        reset;
    logic        sig_in;
    logic        start;
    logic        continuous;
    logic        busy_w, valid_w, ovf_w;
    logic [23:0] cnt_w;
    logic        busy_n, valid_n, ovf_n;
    logic [2:0]  cnt_n;

    int n_checks;
    int n_errors;

    int sig_period;
    int sig_off;
    int sig_id;
    logic sig_level;

    freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .start      (start),
        .continuous (continuous),
        .busy       (busy_w),
        .valid      (valid_w),
        .freq_count (cnt_w),
        .overflow   (ovf_w)
    );

    freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(3)) dut_n (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .start      (start),
        .continuous (continuous),
        .busy       (busy_n),
        .valid      (valid_n),
        .freq_count (cnt_n),
        .overflow   (ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Square wave generator, clk-synchronous so periods are exact.
    initial begin
        int ph;
        int id;
        ph = 0;
        id = -1;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (sig_id != id) begin
                id = sig_id;
                ph = sig_off;
            end
            if (sig_period == 0) begin
                sig_in = sig_level;
            end else begin
                sig_in = (ph < sig_period / 2);
                ph = (ph + 1) % sig_period;
            end
        end
    end

    task automatic set_sig(input int p, input logic lvl, input int off);
        sig_period = p;
        sig_level  = lvl;
        sig_off    = off;
        sig_id     = sig_id + 1;
        repeat (12) @(negedge clk);
    endtask

    task automatic measure(input string tag, input int exp_w,
                           input int exp_n, input int exp_o,
                           input bit spam);
        int n;
        int nb;
        int lat;
        nb  = 0;
        lat = -1;
        start = 1'b1;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = spam && (n % 17 == 0);
            if (valid_w) begin
                lat = n;
                break;
            end
            if (busy_w) nb++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 101);
        check({tag, " busy"}, nb, 100);
        check({tag, " cnt24"}, cnt_w, exp_w);
        check({tag, " ovf24"}, ovf_w, 0);
        check({tag, " valid3"}, valid_n, 1);
        check({tag, " cnt3"}, cnt_n, exp_n);
        check({tag, " ovf3"}, ovf_n, exp_o);
        @(negedge clk);
        check({tag, " pulse"}, valid_w, 0);
        check({tag, " idle"}, busy_w, 0);
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (valid_w) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int vc;
        n_checks   = 0;
        n_errors   = 0;
        sig_period = 0;
        sig_level  = 1'b0;
        sig_off    = 0;
        sig_id     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", busy_w, 0);
        check("rst valid", valid_w, 0);
        check("rst cnt", cnt_w, 0);
        check("rst ovf", ovf_w, 0);
        reset = 1'b0;

        set_sig(10, 1'b0, 0);
        measure("p10", 10, 7, 1, 1'b0);
        set_sig(10, 1'b0, 3 + int'($urandom_range(0, 5)));
        measure("p10ph", 10, 7, 1, 1'b0);
        set_sig(0, 1'b1, 0);
        measure("hi", 0, 0, 0, 1'b0);
        set_sig(0, 1'b0, 0);
        measure("lo", 0, 0, 0, 1'b0);
        set_sig(20, 1'b0, 0);
        measure("p20", 5, 5, 0, 1'b0);
        set_sig(10, 1'b0, 7);
        measure("spam", 10, 7, 1, 1'b1);

        set_sig(4, 1'b0, 0);
        continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(n);
        check("cont lat1", n, 100);
        check("cont cnt1", cnt_w, 25);
        check("cont cnt3", cnt_n, 7);
        check("cont ovf3", ovf_n, 1);
        wait_valid(n);
        check("cont period", n, 101);
        check("cont cnt2", cnt_w, 25);
        repeat (50) @(negedge clk);
        continuous = 1'b0;
        wait_valid(n);
        check("cont last", n, 51);
        check("cont cnt3w", cnt_w, 25);
        @(negedge clk);
        check("cont idle", busy_w, 0);
        repeat (5) @(negedge clk);
        check("cont stay", busy_w, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("abort busy0", busy_w, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", busy_w, 0);
        check("abort valid", valid_w, 0);
        check("abort cnt", cnt_w, 0);
        check("abort ovf3", ovf_n, 0);
        vc = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (valid_w || busy_w) vc++;
        end
        check("abort quiet", vc, 0);
        set_sig(10, 1'b0, 2);
        measure("post", 10, 7, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
